// File: rtl/oflow_sm_line_fetch_pkg.sv
// Shared types and width helpers for the similarity-metric line fetcher.
// The fetch FSM states, the default geometry and the layout of one buffered
// bbox line live here so the fetch block and its users agree on them.
package oflow_sm_line_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lf_state_e;

  localparam int LF_DATA_WIDTH = 96;
  localparam int LF_FIFO_DEPTH = 4;
  localparam int LF_NHF_WIDTH  = 3;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int lf_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LF_CNT_W = lf_cnt_width(LF_FIFO_DEPTH);

  // One bbox line as held in the line FIFO (default geometry).
  typedef struct packed {
    logic [LF_DATA_WIDTH-1:0] data;
    logic                     last;
    logic [LF_NHF_WIDTH-1:0]  frame_idx;
  } lf_line_t;

endpackage

// File: rtl/oflow_sm_line_fetch_fifo.sv
// oflow_sync_fifo: generic first-word-fall-through synchronous FIFO.
// The head entry is visible on pop_data whenever empty is low. Push and pop
// in the same cycle are accepted even when full. DEPTH must be a power of two
// so the pointers wrap naturally.
module oflow_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // A pop frees a slot in the same cycle, so push at full is fine with a pop.
  assign do_pop_s  = pop && (count_q != '0);
  assign do_push_s = push && ((count_q != CNT_W'(DEPTH)) || do_pop_s);

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/oflow_sm_line_fetch.sv
// oflow_sm_line_fetch: paces history-frame line reads out of the MEM buffer
// for the similarity metric, buffers the returned lines in a FWFT FIFO and
// signals done once every requested history frame has been delivered.
// A read is requested only while buffered + in-flight lines leave room in
// the FIFO, so the memory can never overrun it.
// Optional build macro OFLOW_SM_LINE_FETCH_FRAME_CHECK_EN: when defined,
// a returned line whose frame index differs from the expected frame sets
// the sticky err flag (the line is still buffered).
module oflow_sm_line_fetch
  import oflow_sm_line_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = LF_DATA_WIDTH,
  parameter int FIFO_DEPTH = LF_FIFO_DEPTH,
  parameter int NHF_WIDTH  = LF_NHF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  start,
  input  logic [NHF_WIDTH-1:0]  num_of_history_frames,
  output logic                  similarity_metric_flag_ready_to_read_new_line,
  input  logic                  line_valid,
  input  logic [DATA_WIDTH-1:0] line_data,
  input  logic                  line_last,
  input  logic [NHF_WIDTH-1:0]  line_frame_idx,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [NHF_WIDTH-1:0]  out_frame_idx,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W  = lf_cnt_width(FIFO_DEPTH);
  localparam int SUM_W  = CNT_W + 1;
  localparam int LINE_W = DATA_WIDTH + 1 + NHF_WIDTH;

  lf_state_e            state_q, state_d;
  logic [NHF_WIDTH-1:0] nhf_q, nhf_d;
  logic [NHF_WIDTH-1:0] frames_rcvd_q, frames_rcvd_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_W-1:0]     occ_s;
  logic [SUM_W-1:0]     inflight_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 req_s;
  logic                 accept_s;
  logic                 drop_s;
  logic                 pop_s;
  logic                 overflow_s;
  logic                 idx_err_s;
  logic                 final_frame_s;
  logic [LINE_W-1:0]    push_line_s;
  logic [LINE_W-1:0]    head_line_s;

  // Request only while the FIFO can absorb every line already asked for.
  assign inflight_s = SUM_W'(occ_s) + SUM_W'(outstanding_q);
  assign req_s      = (state_q == ST_RUN) && (inflight_s < SUM_W'(FIFO_DEPTH));
  assign similarity_metric_flag_ready_to_read_new_line = req_s;

  // A return with nothing outstanding is unsolicited and dropped.
  assign accept_s   = line_valid && (outstanding_q != '0);
  assign drop_s     = line_valid && (outstanding_q == '0);
  assign pop_s      = out_valid && out_ready;
  // Unreachable under the request rule; kept as a defensive error source.
  assign overflow_s = accept_s && fifo_full_s && !pop_s;

  assign final_frame_s = accept_s && line_last &&
                         ((frames_rcvd_q + NHF_WIDTH'(1)) == nhf_q);

`ifdef OFLOW_SM_LINE_FETCH_FRAME_CHECK_EN
  assign idx_err_s = accept_s && (line_frame_idx != frames_rcvd_q);
`else
  assign idx_err_s = 1'b0;
`endif

  assign push_line_s = {line_last, line_frame_idx, line_data};
  assign {out_last, out_frame_idx, out_data} = head_line_s;
  assign out_valid = !fifo_empty_s;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  oflow_sync_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_N),
    .push      (accept_s),
    .push_data (push_line_s),
    .pop       (pop_s),
    .pop_data  (head_line_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (occ_s)
  );

  // Outstanding-request bookkeeping: +1 per request, -1 per accepted return.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_s, accept_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Session FSM next-state, frame counting and sticky error.
  always_comb begin
    state_d       = state_q;
    nhf_d         = nhf_q;
    frames_rcvd_d = frames_rcvd_q;
    err_d         = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_of_history_frames == '0) begin
            state_d = ST_DONE;
          end else begin
            nhf_d         = num_of_history_frames;
            frames_rcvd_d = '0;
            state_d       = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && line_last) begin
          frames_rcvd_d = frames_rcvd_q + NHF_WIDTH'(1);
          if (final_frame_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((occ_s == '0) && (outstanding_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (drop_s || idx_err_s || overflow_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // Registered status outputs follow the next state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q       <= ST_IDLE;
      nhf_q         <= '0;
      frames_rcvd_q <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nhf_q         <= nhf_d;
      frames_rcvd_q <= frames_rcvd_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_oflow_sm_line_fetch.sv
// Self-checking bench for oflow_sm_line_fetch: a memory model answers every
// request after a (random or fixed) latency, accepted lines are pushed into a
// scoreboard queue, and a negedge monitor pops and compares on each handshake.
// Request pacing and head validity are checked every cycle against counts of
// issued / returned / popped lines.
module tb_oflow_sm_line_fetch;
  import oflow_sm_line_fetch_pkg::*;

  localparam int DW    = 96;
  localparam int DEPTH = 4;
  localparam int NW    = 3;

  logic          clk = 1'b0;
  logic          reset_N = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] num_of_history_frames = '0;
  logic          req;
  logic          line_valid = 1'b0;
  logic [DW-1:0] line_data = '0;
  logic          line_last = 1'b0;
  logic [NW-1:0] line_frame_idx = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [NW-1:0] out_frame_idx;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  oflow_sm_line_fetch #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NHF_WIDTH(NW)) dut (
    .clk(clk), .reset_N(reset_N), .start(start),
    .num_of_history_frames(num_of_history_frames),
    .similarity_metric_flag_ready_to_read_new_line(req),
    .line_valid(line_valid), .line_data(line_data), .line_last(line_last),
    .line_frame_idx(line_frame_idx),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_frame_idx(out_frame_idx), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (cumulative counts; differences give occupancy).
  lf_line_t exp_q[$];
  int  due_q[$];
  int  sizes[$];
  int  issued = 0, returned = 0, popped = 0;
  int  frames_m = 0, nframes_m = 0;
  bit  run_m = 0, active_m = 0;
  bit  req_seen = 0, pop_seen = 0;
  bit  bad_idx_once = 0;
  int  done_cnt = 0, done_base = 0, req_total = 0;
  int  cyc = 0, line_no = 0, lat_fixed = 0, ready_pct = 100;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Attributes of the n-th line of the session; lines past the last frame are fillers.
  function automatic void line_attr(input int n, output logic last, output logic [NW-1:0] idx);
    int acc = 0;
    last = 1'b0;
    idx  = NW'(sizes.size());
    for (int f = 0; f < sizes.size(); f++) begin
      if (n < acc + sizes[f]) begin
        idx  = NW'(f);
        last = (n == acc + sizes[f] - 1);
        return;
      end
      acc += sizes[f];
    end
  endfunction

  // Monitor: per-cycle pacing/validity checks and scoreboard compare on pop.
  always @(negedge clk) begin : mon
    lf_line_t head;
    if (reset_N) begin
      if (req) req_total++;
      req_seen = req;
      pop_seen = out_valid && out_ready;
      if (done) done_cnt++;
      check("req_rule", req, run_m && ((issued - popped) < DEPTH));
      check("out_valid", out_valid, (returned - popped) > 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_unexpected: got line %0h, expected none", out_data);
        end else begin
          head = exp_q.pop_front();
          check("line", {out_data, out_last, out_frame_idx}, head);
        end
      end
    end else begin
      req_seen = 0;
      pop_seen = 0;
    end
  end

  // One clock: account for the cycle just ended, then drive the next one.
  task automatic step();
    bit acc;
    int lat;
    @(posedge clk); #1;
    cyc++;
    acc = line_valid && ((issued - returned) > 0);
    if (acc) begin
      exp_q.push_back('{data: line_data, last: line_last, frame_idx: line_frame_idx});
      returned++;
      if (run_m && line_last) begin
        frames_m++;
        if (frames_m == nframes_m) run_m = 0;
      end
    end
    if (req_seen) begin
      issued++;
      lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
      due_q.push_back(cyc + lat - 1);
    end
    req_seen = 0;
    if (pop_seen) popped++;
    pop_seen = 0;
    if (start && !active_m) begin
      active_m = 1;
      if (num_of_history_frames != '0) begin
        run_m = 1; nframes_m = int'(num_of_history_frames); frames_m = 0;
      end
    end
    start = 0; line_valid = 0; line_last = 0; line_frame_idx = '0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      line_valid = 1;
      line_data  = {$urandom, $urandom, $urandom};
      line_attr(line_no, line_last, line_frame_idx);
      if (bad_idx_once) begin
        line_frame_idx = line_frame_idx + NW'(1);
        bad_idx_once   = 0;
      end
      line_no++;
    end
    out_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic start_sess(input int nf);
    line_no   = 0;
    start     = 1;
    num_of_history_frames = NW'(nf);
    done_base = done_cnt;
  endtask

  task automatic finish_session(input string name, input bit exp_err);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (done_cnt != done_base) ok = 1;
    end
    check({name, " done_seen"}, ok, 1'b1);
    repeat (2) step();
    check({name, " done_once"}, done_cnt - done_base, 1);
    check({name, " busy_idle"}, busy, 1'b0);
    check({name, " err"}, err, exp_err);
    check({name, " sb_empty"}, exp_q.size(), 0);
    active_m = 0; run_m = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int db;
    #2;
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst req", req, 1'b0);
    @(posedge clk); #1;
    reset_N = 1;

    // Two frames of 3 and 2 lines, latency 2, consumer always ready.
    sizes = '{3, 2}; lat_fixed = 2; ready_pct = 100;
    step(); start_sess(2);
    finish_session("basic", 1'b0);

    // Consumer stalled: at most DEPTH requests, then pacing resumes on pops.
    sizes = '{4, 4, 4, 4, 4, 4, 4}; lat_fixed = 1; ready_pct = 0;
    step(); start_sess(7);
    base = req_total;
    repeat (20) step();
    check("stall req_total", req_total - base, DEPTH);
    check("stall out_valid", out_valid, 1'b1);
    ready_pct = 100;
    finish_session("stall", 1'b0);

    // Unsolicited return: dropped, err set; next start clears err.
    step();
    line_valid = 1; line_data = {$urandom, $urandom, $urandom};
    step();
    check("unsol err", err, 1'b1);
    check("unsol out_valid", out_valid, 1'b0);
    sizes = '{2}; lat_fixed = 0;
    start_sess(1);
    step();
    check("unsol err_cleared", err, 1'b0);
    finish_session("after_unsol", 1'b0);

    // Zero frames: DONE the next cycle, one-cycle done, no requests.
    step(); start_sess(0); base = req_total;
    step();
    check("zero done", done, 1'b1);
    check("zero busy", busy, 1'b1);
    step();
    check("zero done_low", done, 1'b0);
    check("zero busy_low", busy, 1'b0);
    check("zero reqs", req_total - base, 0);
    check("zero done_once", done_cnt - done_base, 1);
    active_m = 0;

    // Reset in the middle of a session with three lines buffered.
    sizes = '{4, 4, 4, 4, 4, 4, 4}; lat_fixed = 1; ready_pct = 0;
    step(); start_sess(7);
    for (int i = 0; i < 50 && (returned - popped) < 3; i++) step();
    check("mid buffered", returned - popped, 3);
    #2 reset_N = 0;
    #1;
    check("mid out_valid", out_valid, 1'b0);
    check("mid busy", busy, 1'b0);
    check("mid req", req, 1'b0);
    issued = 0; returned = 0; popped = 0; frames_m = 0;
    run_m = 0; active_m = 0;
    exp_q.delete(); due_q.delete();
    line_valid = 0;
    db = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset_N = 1;
    repeat (5) step();
    check("mid no_done", done_cnt - db, 0);
    check("mid idle", busy, 1'b0);

`ifdef OFLOW_SM_LINE_FETCH_FRAME_CHECK_EN
    // Mis-tagged frame-0 line: err set, line still delivered.
    sizes = '{2, 2}; lat_fixed = 2; ready_pct = 100; bad_idx_once = 1;
    step(); start_sess(2);
    finish_session("fchk", 1'b1);
`endif

    // Randomised sessions, each with a stray start while running.
    for (int s = 0; s < 8; s++) begin
      int nf;
      nf = int'($urandom_range(1, 5));
      sizes.delete();
      for (int f = 0; f < nf; f++) sizes.push_back(int'($urandom_range(1, 4)));
      lat_fixed = 0; ready_pct = int'($urandom_range(30, 100));
      step(); start_sess(nf);
      repeat (2) step();
      start = 1; num_of_history_frames = NW'($urandom_range(0, 7));
      finish_session("rand", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oflow_sm_line_fetch.md
Name: oflow_sm_line_fetch

Overview:
- Downstream consumer of the MEM buffer read path.
- Paces line reads out of the history-frame buffer on behalf of the similarity metric. It asserts similarity_metric_flag_ready_to_read_new_line only when it has room, so memory never overruns it.
- Buffers returned bbox lines in a small FIFO and tracks history-frame boundaries.
- Signals done once all requested history frames have been delivered to the similarity metric core.

Parameters:
- DATA_WIDTH, 96, width of one bbox line read from the MEM buffer.
- FIFO_DEPTH, 4, line FIFO entries; power of two, at least 2.
- NHF_WIDTH, 3, width of the history-frame count (`NUM_OF_HISTORY_FRAMES_WIDTH).

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a fetch session.
- num_of_history_frames  in  NHF_WIDTH  frames to fetch; sampled on start.
- similarity_metric_flag_ready_to_read_new_line  out  1  request one line from the MEM buffer this cycle.
- line_valid  in  1  returned line is present.
- line_data  in  DATA_WIDTH  returned line payload.
- line_last  in  1  returned line is the last line of its history frame.
- line_frame_idx  in  NHF_WIDTH  history-frame index of the returned line.
- out_valid  out  1  FIFO head valid.
- out_data  out  DATA_WIDTH  FIFO head payload.
- out_last  out  1  FIFO head is the last line of its frame.
- out_frame_idx  out  NHF_WIDTH  FIFO head frame index.
- out_ready  in  1  similarity metric accepts the head.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky protocol error; cleared on start.

Behaviour:
- Reset: all outputs 0; FIFO empty; outstanding=0; frames_rcvd=0; state IDLE.
- Counters:
  - occ: FIFO occupancy.
  - outstanding: issued requests not yet returned, width clog2(FIFO_DEPTH)+1.
  - frames_rcvd: NHF_WIDTH bits.
- Request rule: similarity_metric_flag_ready_to_read_new_line = (state==RUN) && (occ+outstanding < FIFO_DEPTH). It is registered-free combinational from registered state. Each asserted cycle counts as one request.
- outstanding update: +1 per request, -1 per accepted line_valid, with both allowed in the same cycle.
- Return: a line_valid arriving with outstanding==0 sets err and the line is dropped. Otherwise the line is pushed into the FIFO.
- FIFO behaviour:
  - First-word-fall-through: out_* reflect the head when out_valid=1.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are legal, including at full.
  - Overflow cannot occur under the request rule.
- FSM states:
  - IDLE:
    - start with num_of_history_frames==0 goes to DONE.
    - start otherwise latches the count, clears frames_rcvd and err, and goes to RUN.
  - RUN: each accepted line with line_last increments frames_rcvd. When frames_rcvd reaches the latched count, go to DRAIN on the same edge; no further requests are issued.
  - DRAIN: when occ==0 and outstanding==0, go to DONE. Late lines are still accepted while outstanding>0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while not IDLE: ignored, no effect.
- Latency: a returned line is visible on out_valid the cycle after line_valid.
- Reset mid-session: state, FIFO and counters clear immediately (asynchronous). done is not pulsed.

Optional Feature:
- Macro: OFLOW_SM_LINE_FETCH_FRAME_CHECK_EN.
- Defined: an accepted line whose line_frame_idx differs from frames_rcvd (the expected index) sets err. The line is still buffered.
- Undefined: line_frame_idx is passed through unchecked and no compare logic is built.

Decomposition:
- Package oflow_sm_line_fetch_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Localparams for counter widths derived from FIFO_DEPTH.
  - A line struct {data, last, frame_idx}.
- Sub-module oflow_sync_fifo: generic FWFT FIFO with push, pop, full, empty and count outputs. It is reused by the fetch block.

Test Plan:
- Reset, then start with num_of_history_frames=2. Memory returns 3 lines (last on the 3rd) for frame 0 and 2 lines for frame 1, with latency 2 and out_ready=1. Expect 5 lines out in order with out_last on lines 3 and 5, done pulses once, err=0.
- Hold out_ready=0 with FIFO_DEPTH=4. Expect at most 4 requests asserted in total, then the request stays low. Raise out_ready and expect one new request per popped line.
- Drive line_valid with no pending request. Expect err=1, the line dropped, and out_valid unchanged. The next start clears err.
- start with num_of_history_frames=0. Expect DONE the next cycle, a one-cycle done pulse, and zero requests.
- Drop reset_N mid-RUN with 3 lines buffered. Expect out_valid=0, busy=0 and request low immediately, and no done pulse.
- With OFLOW_SM_LINE_FETCH_FRAME_CHECK_EN defined, return a frame-0 line tagged line_frame_idx=1. Expect err=1 and the line still delivered.
